mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 46 ++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and owner-tag encoding for the memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int ADDR_W_DEF     = 14;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    // Which requester owns the read data returning from memory next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority decision between fetch and data ports, with a fetch starvation counter.
// Latency: grants are combinational from req and the registered counter.
// Backpressure: data wins ties; fetch wins once it has been denied STARVE_MAX cycles in a row.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starve_win;

    // Grant decision; reset masks both grants so nothing reaches memory.
    always_comb begin
        starve_win = i_req && (starve_q == CNT_MAX);
        d_gnt      = rst_n && d_req && !starve_win;
        i_gnt      = rst_n && i_req && !(d_req && !starve_win);
    end

    // Count consecutive denied fetch cycles, saturating; any fetch grant or idle fetch clears it.
    always_comb begin
        starve_d = '0;
        if (i_req && !i_gnt) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory with 1-cycle read latency; optional MEM_ARB_PERF_EN adds w_conflicts.
// Latency: grant and memory command in the request cycle; rvalid/rdata the following cycle, back-to-back without bubbles.
// Backpressure: a requester holds req and its fields until it sees gnt; rvalid cannot be stalled.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         w_conflicts
`endif
);

    owner_e owner_q;
    owner_e owner_d;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .i_req (i_req),
        .d_req (d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    // Steer the granted port onto the memory command; fetches are full-word reads.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_be    = '1;
            m_addr  = i_addr;
        end
    end

    // Tag the owner of a read issued this cycle; writes return nothing.
    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt && !d_we) begin
            owner_d = OWN_DATA;
        end else if (i_gnt) begin
            owner_d = OWN_IF;
        end
    end

    // Owner tag register, one entry deep because memory latency is exactly one cycle.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Reset also masks rvalid so a read issued just before reset never surfaces.
    always_comb begin
        i_rvalid = w_rst_n && (owner_q == OWN_IF);
        d_rvalid = w_rst_n && (owner_q == OWN_DATA);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflicts_q;
    logic [31:0] conflicts_d;

    // Count cycles where both ports request, saturating at all-ones.
    always_comb begin
        conflicts_d = conflicts_q;
        if (i_req && d_req && (conflicts_q != '1)) begin
            conflicts_d = conflicts_q + 32'd1;
        end
    end

    // Conflict counter register.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            conflicts_q <= '0;
        end else begin
            conflicts_q <= conflicts_d;
        end
    end

    assign w_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// The memory model returns 0xC0DE0000 | addr one cycle after a read.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic                w_clk = 1'b0;
    logic                w_rst_n;
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic                i_gnt;
    logic                i_rvalid;
    logic [DATA_W-1:0]   i_rdata;
    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_be;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [DATA_W-1:0]   d_rdata;
    logic                m_en;
    logic                m_we;
    logic [DATA_W/8-1:0] m_be;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W-1:0]   m_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]         w_conflicts;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .w_clk    (w_clk),
        .w_rst_n  (w_rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .w_conflicts (w_conflicts)
`endif
    );

    always #5 w_clk = ~w_clk;

    // Single-port memory model with one-cycle read latency.
    always @(posedge w_clk) begin
        if (m_en && !m_we) begin
            m_rdata <= 32'hC0DE_0000 | 32'(m_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle();
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = '0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    logic [ADDR_W-1:0] alt_addr [4];
    logic              alt_is_d [4];

    initial begin
        alt_addr[0] = 14'h001; alt_is_d[0] = 1'b0;
        alt_addr[1] = 14'h002; alt_is_d[1] = 1'b1;
        alt_addr[2] = 14'h003; alt_is_d[2] = 1'b0;
        alt_addr[3] = 14'h004; alt_is_d[3] = 1'b1;

        // Reset with both ports requesting: grants and m_en must be masked.
        idle();
        w_rst_n = 1'b0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        tick();
        tick();
        @(negedge w_clk);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_en",  m_en,  0);
        tick();
        w_rst_n = 1'b1;
        idle();
        @(negedge w_clk);
        chk("post_rst_i_rvalid", i_rvalid, 0);
        chk("post_rst_d_rvalid", d_rvalid, 0);
        chk("post_rst_m_we",     m_we,     0);
        chk("idle_m_en",         m_en,     0);
        chk("idle_gnt",          {i_gnt, d_gnt}, 0);

        // Lone fetch.
        tick();
        i_req  = 1'b1;
        i_addr = 14'h010;
        @(negedge w_clk);
        chk("if_gnt",    i_gnt,  1);
        chk("if_m_en",   m_en,   1);
        chk("if_m_we",   m_we,   0);
        chk("if_m_be",   m_be,   4'hF);
        chk("if_m_addr", m_addr, 14'h010);
        tick();
        idle();
        @(negedge w_clk);
        chk("if_rvalid",   i_rvalid, 1);
        chk("if_rdata",    i_rdata,  32'hC0DE_0010);
        chk("if_d_rvalid", d_rvalid, 0);

        // Lone data write.
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 14'h020;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'b0011;
        @(negedge w_clk);
        chk("wr_gnt",     d_gnt,   1);
        chk("wr_m_we",    m_we,    1);
        chk("wr_m_be",    m_be,    4'b0011);
        chk("wr_m_addr",  m_addr,  14'h020);
        chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
        tick();
        idle();
        @(negedge w_clk);
        chk("wr_no_d_rvalid", d_rvalid, 0);
        chk("wr_no_i_rvalid", i_rvalid, 0);

        // Contention for 10 cycles: fetch wins only in cycles 4 and 9.
        tick();
        i_req  = 1'b1;
        i_addr = 14'h100;
        d_req  = 1'b1;
        d_addr = 14'h200;
        for (int c = 0; c < 10; c++) begin
            @(negedge w_clk);
            chk($sformatf("starve_d_gnt_c%0d", c), d_gnt, (c == 4 || c == 9) ? 1'b0 : 1'b1);
            chk($sformatf("starve_i_gnt_c%0d", c), i_gnt, (c == 4 || c == 9) ? 1'b1 : 1'b0);
            tick();
        end
        idle();
        tick();

        // Alternating fetch/data reads on consecutive cycles.
        for (int k = 0; k <= 4; k++) begin
            idle();
            if (k < 4) begin
                if (alt_is_d[k]) begin
                    d_req  = 1'b1;
                    d_addr = alt_addr[k];
                end else begin
                    i_req  = 1'b1;
                    i_addr = alt_addr[k];
                end
            end
            @(negedge w_clk);
            if (k > 0) begin
                chk($sformatf("alt_i_rvalid_%0d", k), i_rvalid, !alt_is_d[k-1]);
                chk($sformatf("alt_d_rvalid_%0d", k), d_rvalid, alt_is_d[k-1]);
                chk($sformatf("alt_rdata_%0d", k),    d_rdata,  32'hC0DE_0000 | 32'(alt_addr[k-1]));
            end
            if (k < 4) begin
                chk($sformatf("alt_m_addr_%0d", k), m_addr, alt_addr[k]);
            end
            tick();
        end

        // Read granted just before reset: never returned; counters cleared.
        idle();
        i_req  = 1'b1;
        i_addr = 14'h007;
        d_req  = 1'b1;
        d_addr = 14'h008;
        @(negedge w_clk);
        chk("prerst_d_gnt", d_gnt, 1);
        tick();
        idle();
        w_rst_n = 1'b0;
        @(negedge w_clk);
        chk("inrst_d_rvalid", d_rvalid, 0);
        chk("inrst_i_rvalid", i_rvalid, 0);
        tick();
        @(negedge w_clk);
        chk("inrst_starve_cnt", 64'(dut.u_prio.starve_q), 0);
        chk("inrst2_d_rvalid", d_rvalid, 0);
`ifdef MEM_ARB_PERF_EN
        chk("inrst_conflicts", w_conflicts, 0);
`endif
        tick();
        w_rst_n = 1'b1;
        @(negedge w_clk);
        chk("afterrst_d_rvalid", d_rvalid, 0);
        chk("afterrst_i_rvalid", i_rvalid, 0);
        chk("afterrst_m_we",     m_we,     0);

`ifdef MEM_ARB_PERF_EN
        // Seven cycles of simultaneous requests.
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
        end
        idle();
        @(negedge w_clk);
        chk("perf_conflicts", w_conflicts, 7);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
